// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage: scalar widths, the F/D
// pipeline register layout and the fetch FSM state encoding.
package fetch_stage_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    localparam u64 PC_INIT_DEFAULT = 64'h8000_0000;

    typedef struct packed {
        logic valid;
        u64   pc;
        u32   raw_instr;
    } fetch_data_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    // Bit 2 of the fetch address picks the 32-bit half of the 8-byte bus word.
    function automatic u32 select_instr(input logic upper_half, input u64 word);
        return upper_half ? word[63:32] : word[31:0];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction bus between the fetch stage (master) and the instruction memory
// (slave): one outstanding request, completed by iresp_data_ok.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic ireq_valid;
    u64   ireq_addr;
    logic iresp_data_ok;
    u64   iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_data_ok,
        output iresp_data
    );

endinterface

// File: rtl/fetch_skid.sv
// Single-entry {pc, instr} holding register that parks a fetched instruction
// while decode is stalled.
module fetch_skid
    import fetch_stage_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  u64   pc_in,
    input  u32   instr_in,
    output u64   pc,
    output u32   instr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= '0;
            instr <= '0;
        end else if (clear) begin
            pc    <= '0;
            instr <= '0;
        end else if (load) begin
            pc    <= pc_in;
            instr <= instr_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the instruction bus and
// fills the F/D register, with a one-entry skid buffer and redirect handling.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | just out of reset, no request yet
//   REQ     | request for pc outstanding on the bus
//   HOLD    | skid buffer full, decode stalled, no request
//   DISCARD | draining a request killed by a redirect
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter u64 PC_INIT = PC_INIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  u64                    redirect_pc,
    fetch_stage_if.master         ibus,
    output fetch_data_t           dataF
);

    fetch_state_t state, state_nxt;
    u64           pc, pc_nxt;
    u64           pend_pc, pend_pc_nxt;
    fetch_data_t  data_nxt;
    logic         skid_load;
    logic         skid_clear;
    u64           skid_pc;
    u32           skid_instr;
    u64           redirect_tgt;
    u32           fetched_instr;
    logic         unused_redirect_lsbs;

    assign redirect_tgt         = {redirect_pc[63:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign fetched_instr        = select_instr(pc[2], ibus.iresp_data);

    fetch_skid u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load),
        .clear    (skid_clear),
        .pc_in    (pc),
        .instr_in (fetched_instr),
        .pc       (skid_pc),
        .instr    (skid_instr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pend_pc_nxt = pend_pc;
        data_nxt    = dataF;
        skid_load   = 1'b0;
        skid_clear  = 1'b0;

        if (redirect_valid) begin
            data_nxt.valid = 1'b0;
            skid_clear     = 1'b1;
            unique case (state)
                IDLE: begin
                    pc_nxt    = redirect_tgt;
                    state_nxt = REQ;
                end
                REQ: begin
                    if (ibus.iresp_data_ok) begin
                        pc_nxt = redirect_tgt;
                    end else begin
                        pend_pc_nxt = redirect_tgt;
                        state_nxt   = DISCARD;
                    end
                end
                HOLD: begin
                    pc_nxt    = redirect_tgt;
                    state_nxt = REQ;
                end
                DISCARD: begin
                    // The killed request may complete in the same cycle as a
                    // newer redirect; the newest target is fetched next.
                    if (ibus.iresp_data_ok) begin
                        pc_nxt    = redirect_tgt;
                        state_nxt = REQ;
                    end else begin
                        pend_pc_nxt = redirect_tgt;
                    end
                end
            endcase
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = REQ;
                end
                REQ: begin
                    if (ibus.iresp_data_ok) begin
                        pc_nxt = pc + 64'd4;
                        if (stall) begin
                            skid_load = 1'b1;
                            state_nxt = HOLD;
                        end else begin
                            data_nxt = '{valid: 1'b1, pc: pc, raw_instr: fetched_instr};
                        end
                    end else if (!stall) begin
                        data_nxt.valid = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        data_nxt  = '{valid: 1'b1, pc: skid_pc, raw_instr: skid_instr};
                        state_nxt = REQ;
                    end
                end
                DISCARD: begin
                    if (ibus.iresp_data_ok) begin
                        pc_nxt    = pend_pc;
                        state_nxt = REQ;
                    end
                end
            endcase
        end
    end

    // In DISCARD pc still holds the killed address, so the bus address is pc
    // in every state.
    always_comb begin
        ibus.ireq_valid = (state == REQ) || (state == DISCARD);
        ibus.ireq_addr  = pc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= PC_INIT;
            pend_pc <= '0;
            dataF   <= '0;
        end else begin
            pc      <= pc_nxt;
            pend_pc <= pend_pc_nxt;
            dataF   <= data_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a scripted instruction bus driven one cycle
// at a time, with hand-computed expectations for each cycle of interest.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk;
    logic reset;
    logic stall;
    logic redirect_valid;
    u64   redirect_pc;
    fetch_data_t dataF;

    int n_chk;
    int n_pass;

    fetch_stage_if bus ();

    fetch_stage #(.PC_INIT(64'h8000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ibus           (bus.master),
        .dataF          (dataF)
    );

    always #5 clk = ~clk;

    function automatic u32 instr_of(input u64 a);
        if (a == 64'h8000_0000) return 32'h0000_0013;
        if (a == 64'h8000_0004) return 32'h0010_0093;
        return a[31:0] ^ a[63:32] ^ 32'h5a5a_0003;
    endfunction

    function automatic u64 mem_word(input u64 a);
        u64 base;
        base = {a[63:3], 3'b000};
        return {instr_of(base | 64'd4), instr_of(base)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        else
            n_pass++;
    endtask

    // Advance one clock and sample 1 ns after the edge; the bus word follows
    // the current request address.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.iresp_data = mem_word(bus.ireq_addr);
    endtask

    function automatic fetch_data_t fd(input u64 pc);
        return '{valid: 1'b1, pc: pc, raw_instr: instr_of(pc)};
    endfunction

    initial begin
        n_chk          = 0;
        n_pass         = 0;
        clk            = 1'b0;
        reset          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus.iresp_data_ok = 1'b0;
        bus.iresp_data    = '0;

        tick();
        tick();
        chk("rst_valid", bus.ireq_valid, 1'b0);
        chk("rst_addr", bus.ireq_addr, 64'h8000_0000);
        chk("rst_dataF", dataF, '0);

        // Zero-wait bus from reset release.
        reset = 1'b1;
        tick();
        chk("first_req_valid", bus.ireq_valid, 1'b1);
        chk("first_req_addr", bus.ireq_addr, 64'h8000_0000);
        chk("first_bus_word", bus.iresp_data, 64'h0010_0093_0000_0013);
        chk("idle_no_data", dataF.valid, 1'b0);
        bus.iresp_data_ok = 1'b1;
        tick();
        chk("f0_dataF", dataF, {1'b1, 64'h8000_0000, 32'h0000_0013});
        chk("f1_addr", bus.ireq_addr, 64'h8000_0004);
        tick();
        chk("f1_dataF", dataF, {1'b1, 64'h8000_0004, 32'h0010_0093});
        chk("f2_addr", bus.ireq_addr, 64'h8000_0008);

        // Stall for 4 cycles while 0x80000008 returns.
        stall = 1'b1;
        tick();
        bus.iresp_data_ok = 1'b0;
        chk("hold_no_req", bus.ireq_valid, 1'b0);
        chk("hold_dataF_0", dataF, {1'b1, 64'h8000_0004, 32'h0010_0093});
        tick();
        chk("hold_dataF_1", dataF, {1'b1, 64'h8000_0004, 32'h0010_0093});
        tick();
        chk("hold_no_req_2", bus.ireq_valid, 1'b0);
        tick();
        chk("hold_dataF_3", dataF, {1'b1, 64'h8000_0004, 32'h0010_0093});
        stall = 1'b0;
        tick();
        chk("skid_dataF", dataF, fd(64'h8000_0008));
        chk("after_hold_valid", bus.ireq_valid, 1'b1);
        chk("after_hold_addr", bus.ireq_addr, 64'h8000_000C);

        // 3-cycle latency on 0x8000000C.
        tick();
        chk("lat_bubble_0", dataF.valid, 1'b0);
        chk("lat_addr_0", bus.ireq_addr, 64'h8000_000C);
        tick();
        chk("lat_bubble_1", dataF.valid, 1'b0);
        chk("lat_valid_1", bus.ireq_valid, 1'b1);
        chk("lat_addr_1", bus.ireq_addr, 64'h8000_000C);
        bus.iresp_data_ok = 1'b1;
        tick();
        bus.iresp_data_ok = 1'b0;
        chk("lat_dataF", dataF, fd(64'h8000_000C));
        chk("lat_next_addr", bus.ireq_addr, 64'h8000_0010);
        tick();
        chk("lat_one_shot", dataF.valid, 1'b0);

        // Redirect while 0x80000010 is pending; its data arrives 2 cycles on.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        chk("disc_dataF_valid", dataF.valid, 1'b0);
        chk("disc_req_valid", bus.ireq_valid, 1'b1);
        chk("disc_addr_0", bus.ireq_addr, 64'h8000_0010);
        tick();
        chk("disc_addr_1", bus.ireq_addr, 64'h8000_0010);
        bus.iresp_data_ok = 1'b1;
        tick();
        chk("disc_dropped", dataF.valid, 1'b0);
        chk("disc_target_addr", bus.ireq_addr, 64'h8000_0100);
        tick();
        chk("redir_dataF", dataF, fd(64'h8000_0100));

        // Redirect coincident with data_ok and stall; low bits of target ignored.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0203;
        stall          = 1'b1;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        chk("coinc_no_hold", bus.ireq_valid, 1'b1);
        chk("coinc_addr", bus.ireq_addr, 64'h8000_0200);
        chk("coinc_dataF_valid", dataF.valid, 1'b0);
        tick();
        chk("coinc_next_dataF", dataF, fd(64'h8000_0200));

        // Redirect out of HOLD drops the skid entry.
        stall = 1'b1;
        tick();
        chk("hold2_no_req", bus.ireq_valid, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        chk("hold_redir_valid", bus.ireq_valid, 1'b1);
        chk("hold_redir_addr", bus.ireq_addr, 64'h8000_0300);
        chk("hold_redir_dataF_valid", dataF.valid, 1'b0);
        tick();
        chk("hold_redir_dataF", dataF, fd(64'h8000_0300));

        // Reset mid-request.
        bus.iresp_data_ok = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_req_valid", bus.ireq_valid, 1'b0);
        chk("mid_rst_dataF_valid", dataF.valid, 1'b0);
        chk("mid_rst_addr", bus.ireq_addr, 64'h8000_0000);
        tick();
        reset = 1'b1;
        bus.iresp_data_ok = 1'b1;
        tick();
        chk("restart_addr", bus.ireq_addr, 64'h8000_0000);
        chk("restart_valid", bus.ireq_valid, 1'b1);
        tick();
        chk("restart_dataF", dataF, {1'b1, 64'h8000_0000, 32'h0000_0013});

        // PC wraps modulo 2^64.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_addr", bus.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("wrap_dataF", dataF, fd(64'hFFFF_FFFF_FFFF_FFFC));
        chk("wrap_next_addr", bus.ireq_addr, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV64 pipeline, directly upstream of decode.
- Owns the fetch PC and drives the instruction bus with a valid/data_ok handshake.
- Selects the 32-bit instruction out of the 64-bit bus word.
- Registers the result into the F/D pipeline register (fetch_data_t) that decode consumes.
- Handles hazard stalls with a one-entry skid buffer, and branch/jump redirects, including discarding in-flight responses.

Parameters:
- PC_INIT, 64'h8000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- stall  in  1  hazard unit: decode cannot accept; hold dataF.
- redirect_valid  in  1  execute-stage control transfer taken this cycle.
- redirect_pc  in  64  redirect target; bits [1:0] ignored, treated as 0.
- ireq_valid  out  1  instruction bus request valid.
- ireq_addr  out  64  request address.
- iresp_data_ok  in  1  response valid; completes the current request.
- iresp_data  in  64  8-byte-aligned bus word.
- dataF  out  fetch_data_t  registered {valid, pc[63:0], raw_instr[31:0]} to decode.

Behaviour:
- States:
  - IDLE: reset only.
  - REQ: request outstanding.
  - HOLD: skid buffer full, no request.
  - DISCARD: draining a request killed by redirect.
- Registers: state, pc, pend_pc, skid {pc, instr}, dataF.
- Reset (async, reset=0):
  - state=IDLE, pc=PC_INIT, dataF all-zero (valid=0), skid cleared.
  - ireq_valid=0, ireq_addr=PC_INIT.
- Outputs (combinational from state):
  - ireq_valid=1 in REQ and DISCARD.
  - ireq_addr=pc in REQ, the killed address in DISCARD.
- Bus rule: once ireq_valid rises, the address stays stable and valid stays high until the cycle iresp_data_ok=1. The request is never withdrawn.
- Instruction select: raw_instr = ireq_addr[2] ? iresp_data[63:32] : iresp_data[31:0].
- IDLE -> REQ unconditionally on the first clock after reset release. The first request is visible one cycle after reset deasserts.
- REQ, data_ok=1, no redirect, stall=0: dataF <= {1, pc, instr}; pc <= pc+4; stay REQ. This gives back-to-back fetch, one instruction per cycle with a zero-wait bus.
- REQ, data_ok=1, no redirect, stall=1: dataF unchanged; skid <= {pc, instr}; pc <= pc+4; -> HOLD.
- REQ, data_ok=0: if stall=0, dataF.valid <= 0 (bubble); otherwise hold.
- HOLD, stall=0: dataF <= {1, skid}; -> REQ.
- HOLD, stall=1: hold everything.
- Redirect has priority over stall and data in every state. On any redirect: dataF.valid <= 0, skid dropped.
  - REQ with data_ok=1 the same cycle: response discarded; pc <= redirect_pc; stay REQ.
  - REQ with data_ok=0: pend_pc <= redirect_pc; -> DISCARD.
  - HOLD: pc <= redirect_pc; -> REQ.
  - DISCARD: pend_pc <= redirect_pc (latest redirect wins).
  - IDLE: pc <= redirect_pc.
- DISCARD, data_ok=1, no new redirect: data dropped; pc <= pend_pc; -> REQ.
- While stall=1 and no redirect, dataF is bit-for-bit stable.
- PC arithmetic: 64-bit, wraps modulo 2^64; no overflow detection.
- Reset asserted mid-request: immediate return to reset values. The bus must tolerate the abandoned request.

Decomposition:
- pipes package: fetch_data_t {valid, pc, raw_instr}, fetch_state_t enum {IDLE, REQ, HOLD, DISCARD}.
- common package: u64, u32, PC_INIT default.
- One sub-module, fetch_skid: the single-entry {pc, instr} holding register with load/clear.
- The FSM and PC logic stay in fetch_stage.

Test Plan:
- Reset release with a zero-wait bus returning 0x00000013 at 0x80000000 and 0x00100093 at 0x80000004 (same word, data=64'h00100093_00000013) -> ireq_addr 0x80000000 then 0x80000004; dataF {1, 0x80000000, 0x00000013} then {1, 0x80000004, 0x00100093}.
- 3-cycle bus latency -> ireq_valid and addr stable for 3 cycles; dataF.valid=0 during the wait, 1 for one cycle after data_ok.
- stall=1 for 4 cycles while data_ok arrives for 0x80000008 -> dataF holds the 0x80000004 entry; state HOLD, ireq_valid=0; after stall drops dataF={1, 0x80000008, ...} and the next request is 0x8000000C.
- redirect to 0x80000100 while the 0x80000010 request is pending (data_ok 2 cycles later) -> dataF.valid=0; addr stays 0x80000010 until data_ok; that data is never in dataF; next request 0x80000100.
- redirect coincident with data_ok and stall=1 -> response dropped, no HOLD; next ireq_addr = redirect target; dataF.valid=0.
- reset pulled low mid-request -> ireq_valid=0 and dataF.valid=0 the same cycle; after release, the fetch restarts at 0x80000000.
